// File: rtl/fp_mul_pipe.sv
// rtl/fp_mul_pipe.sv - 3-stage pipelined floating-point multiplier, round-to-nearest-even
// Denormal inputs read as zero and tiny results flush to zero; one global stall from out_ready.
module fp_mul_pipe #(
  parameter int EW = 8,
  parameter int MW = 23,
  localparam int W = 1 + EW + MW,
  localparam int BIAS = (1 << (EW - 1)) - 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [3:0]   out_flags
);

  localparam int PW = 2 * MW + 2;
  localparam int XW = EW + 2;
  localparam logic [XW-1:0] EMAX = XW'((1 << EW) - 1);

  typedef enum logic [1:0] {CLS_NORM, CLS_ZERO, CLS_INF, CLS_NAN} cls_t;

  logic stall;
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  // S1: unpack, classify, full-width mantissa product
  logic          sa, sb;
  logic [EW-1:0] ea, eb;
  logic [MW-1:0] fa, fb;
  logic          a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
  cls_t          c1_cls;
  logic          c1_inv;
  logic [PW-1:0] c1_prod;
  logic [XW-1:0] c1_exp;

  assign {sa, ea, fa} = A;
  assign {sb, eb, fb} = B;
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (&ea) && (fa == '0);
  assign b_inf  = (&eb) && (fb == '0);
  assign a_nan  = (&ea) && (fa != '0);
  assign b_nan  = (&eb) && (fb != '0);
  assign a_snan = a_nan && !fa[MW-1];
  assign b_snan = b_nan && !fb[MW-1];
  assign c1_prod = PW'({1'b1, fa}) * PW'({1'b1, fb});
  assign c1_exp  = XW'(ea) + XW'(eb) - XW'(BIAS);

  always_comb begin
    c1_cls = CLS_NORM;
    c1_inv = 1'b0;
    if (a_nan || b_nan) begin
      c1_cls = CLS_NAN;
      c1_inv = a_snan || b_snan;
    end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
      c1_cls = CLS_NAN;
      c1_inv = 1'b1;
    end else if (a_inf || b_inf) begin
      c1_cls = CLS_INF;
    end else if (a_zero || b_zero) begin
      c1_cls = CLS_ZERO;
    end
  end

  logic          s1_valid, s1_sign, s1_inv;
  cls_t          s1_cls;
  logic [PW-1:0] s1_prod;
  logic [XW-1:0] s1_exp;

  // S2: normalise to a leading one and extract guard/round/sticky
  logic          c2_norm, c2_g, c2_r, c2_st;
  logic [MW-1:0] c2_frac;
  logic [XW-1:0] c2_exp;

  assign c2_norm = s1_prod[PW-1];
  assign c2_frac = c2_norm ? s1_prod[2*MW:MW+1] : s1_prod[2*MW-1:MW];
  assign c2_g    = c2_norm ? s1_prod[MW]        : s1_prod[MW-1];
  assign c2_r    = c2_norm ? s1_prod[MW-1]      : s1_prod[MW-2];
  assign c2_st   = c2_norm ? |s1_prod[MW-2:0]   : |s1_prod[MW-3:0];
  assign c2_exp  = s1_exp + XW'(c2_norm);

  logic          s2_valid, s2_sign, s2_inv, s2_g, s2_r, s2_st;
  cls_t          s2_cls;
  logic [MW-1:0] s2_frac;
  logic [XW-1:0] s2_exp;

  // S3: round, renormalise on carry, then range-check the final exponent
  logic          c3_inc, c3_inexact;
  logic [MW:0]   c3_sum;
  logic [XW-1:0] c3_exp;
  logic [W-1:0]  c3_data;
  logic [3:0]    c3_flags;

  assign c3_inc     = s2_g && (s2_r || s2_st || s2_frac[0]);
  assign c3_inexact = s2_g || s2_r || s2_st;
  assign c3_sum     = {1'b0, s2_frac} + (MW+1)'(c3_inc);
  assign c3_exp     = s2_exp + XW'(c3_sum[MW]);

  always_comb begin
    c3_data  = {s2_sign, c3_exp[EW-1:0], c3_sum[MW-1:0]};
    c3_flags = {3'b000, c3_inexact};
    case (s2_cls)
      CLS_NAN: begin
        c3_data  = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
        c3_flags = {s2_inv, 3'b000};
      end
      CLS_INF: begin
        c3_data  = {s2_sign, {EW{1'b1}}, {MW{1'b0}}};
        c3_flags = 4'b0000;
      end
      CLS_ZERO: begin
        c3_data  = {s2_sign, {(EW+MW){1'b0}}};
        c3_flags = 4'b0000;
      end
      default: begin
        if (!c3_exp[XW-1] && c3_exp >= EMAX) begin
          c3_data  = {s2_sign, {EW{1'b1}}, {MW{1'b0}}};
          c3_flags = 4'b0101;
        end else if (c3_exp[XW-1] || c3_exp == '0) begin
          c3_data  = {s2_sign, {(EW+MW){1'b0}}};
          c3_flags = 4'b0011;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_flags <= '0;
    end else if (!stall) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
      out_data  <= c3_data;
      out_flags <= c3_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (!stall) begin
      s1_sign <= sa ^ sb;
      s1_inv  <= c1_inv;
      s1_cls  <= c1_cls;
      s1_prod <= c1_prod;
      s1_exp  <= c1_exp;
      s2_sign <= s1_sign;
      s2_inv  <= s1_inv;
      s2_cls  <= s1_cls;
      s2_frac <= c2_frac;
      s2_g    <= c2_g;
      s2_r    <= c2_r;
      s2_st   <= c2_st;
      s2_exp  <= c2_exp;
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb/tb_fp_mul_pipe.sv - bench for fp_mul_pipe (EW=8, MW=23)
// Scoreboard of expected results from an integer-arithmetic reference model.
module tb_fp_mul_pipe;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] A, B, out_data;
  logic [3:0]  out_flags;

  fp_mul_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  f;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t        q[$];
  int          checks = 0, errors = 0, cyc_n = 0;
  bit          lat_mode = 1'b1, last_acc = 1'b0, held = 1'b0;
  logic [35:0] held_v;
  logic [31:0] cur_d;
  logic [3:0]  cur_f;

  logic [31:0] da[7] = '{32'h40400000, 32'h3F800001, 32'hBF800000, 32'h7F7FFFFF,
                         32'h00800000, 32'h7F800000, 32'hFF800000};
  logic [31:0] db[7] = '{32'h40000000, 32'h3F800001, 32'h3F800000, 32'h40000000,
                         32'h3F000000, 32'h00000000, 32'h40000000};
  logic [31:0] dr[7] = '{32'h40C00000, 32'h3F800002, 32'hBF800000, 32'h7F800000,
                         32'h00000000, 32'h7FC00000, 32'hFF800000};
  logic [3:0]  df[7] = '{4'b0000, 4'b0001, 4'b0000, 4'b0101, 4'b0011, 4'b1000, 4'b0000};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Exact product then round-to-nearest-even by remainder comparison.
  function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [3:0] f);
    logic            s;
    logic [22:0]     fa, fb;
    int              ea, eb, e, sh;
    bit              nan_a, nan_b, snan_a, snan_b, inf_a, inf_b, z_a, z_b;
    longint unsigned p, qv, rem, half;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    fa = a[22:0];
    fb = b[22:0];
    nan_a = (ea == 255) && (fa != 0);
    nan_b = (eb == 255) && (fb != 0);
    snan_a = nan_a && !fa[22];
    snan_b = nan_b && !fb[22];
    inf_a = (ea == 255) && (fa == 0);
    inf_b = (eb == 255) && (fb == 0);
    z_a = (ea == 0);
    z_b = (eb == 0);
    if (nan_a || nan_b) begin
      r = 32'h7FC00000;
      f = {snan_a || snan_b, 3'b000};
    end else if ((inf_a && z_b) || (inf_b && z_a)) begin
      r = 32'h7FC00000;
      f = 4'b1000;
    end else if (inf_a || inf_b) begin
      r = {s, 8'hFF, 23'd0};
      f = 4'b0000;
    end else if (z_a || z_b) begin
      r = {s, 31'd0};
      f = 4'b0000;
    end else begin
      p  = (64'(fa) + (64'd1 << 23)) * (64'(fb) + (64'd1 << 23));
      e  = ea + eb - 127;
      sh = (p >= (64'd1 << 47)) ? 24 : 23;
      if (sh == 24) e = e + 1;
      qv   = p >> sh;
      rem  = p - (qv << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && qv[0])) qv = qv + 1;
      if (qv == (64'd1 << 24)) begin
        qv = qv >> 1;
        e  = e + 1;
      end
      if (e >= 255) begin
        r = {s, 8'hFF, 23'd0};
        f = 4'b0101;
      end else if (e <= 0) begin
        r = {s, 31'd0};
        f = 4'b0011;
      end else begin
        r = {s, e[7:0], qv[22:0]};
        f = {3'b000, rem != 0};
      end
    end
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [7:0]  e;
    logic [22:0] f;
    int          k;
    k = $urandom_range(0, 9);
    f = 23'($urandom);
    case (k)
      0: e = 8'd0;
      1: begin e = 8'hFF; f = 23'd0; end
      2: e = 8'hFF;
      3: e = 8'($urandom_range(1, 20));
      4: e = 8'($urandom_range(230, 254));
      5: begin e = 8'($urandom_range(100, 154)); f = '1; end
      default: e = 8'($urandom_range(100, 154));
    endcase
    return {1'($urandom), e, f};
  endfunction

  // Observe handshakes mid-cycle, then advance one clock; inputs change at posedge+1.
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    last_acc = 1'b0;
    if (!rst) begin
      chk("in_ready_rule", 64'(in_ready), 64'(!(out_valid && !out_ready)));
      if (held) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_data", 64'({out_flags, out_data}), 64'(held_v));
      end
      held   = out_valid && !out_ready;
      held_v = {out_flags, out_data};
      if (out_valid) begin
        if (q.size() == 0) chk("spurious_valid", 64'(out_valid), 64'd0);
        else if (out_ready) begin
          e = q.pop_front();
          chk("data", 64'(out_data), 64'(e.d));
          chk("flags", 64'(out_flags), 64'(e.f));
          if (e.lat) chk("latency", 64'(cyc_n - e.acc), 64'd3);
        end
      end
      if (in_valid && in_ready) begin
        e.d = cur_d;
        e.f = cur_f;
        e.acc = cyc_n;
        e.lat = lat_mode;
        q.push_back(e);
        last_acc = 1'b1;
      end
    end else begin
      held = 1'b0;
    end
    @(posedge clk);
    if (rst) q.delete();
    cyc_n++;
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && q.size() > 0; k++) cyc();
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    int          idx;
    bit          pending;
    logic [31:0] sa_arr[6], sb_arr[6];

    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    A = 32'h40400000; B = 32'h40000000; cur_d = 32'h40C00000; cur_f = 4'b0000;
    repeat (3) cyc();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_flags", 64'(out_flags), 64'd0);
    rst = 1'b0; in_valid = 1'b0;
    repeat (5) cyc();
    chk("rst_no_result", 64'(out_valid), 64'd0);

    for (int i = 0; i < 7; i++) begin
      A = da[i]; B = db[i]; cur_d = dr[i]; cur_f = df[i];
      in_valid = 1'b1;
      cyc();
      chk("dir_accept", 64'(last_acc), 64'd1);
      in_valid = 1'b0;
      drain();
    end

    for (int i = 0; i < 200; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      A = rnd_op(); B = rnd_op();
      ref_mul(A, B, cur_d, cur_f);
      cyc();
    end
    in_valid = 1'b0;
    drain();

    lat_mode = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sa_arr[i] = rnd_op();
      sb_arr[i] = rnd_op();
    end
    idx = 0;
    for (int k = 0; k < 40 && (idx < 6 || q.size() > 0); k++) begin
      out_ready = !(k >= 4 && k <= 7);
      if (idx < 6) begin
        in_valid = 1'b1; A = sa_arr[idx]; B = sb_arr[idx];
        ref_mul(A, B, cur_d, cur_f);
      end else in_valid = 1'b0;
      if (k >= 4 && k <= 7) begin
        #1;
        chk("stall_in_ready", 64'(in_ready), 64'd0);
      end
      cyc();
      if (last_acc) idx++;
    end
    chk("stall_all_sent", 64'(idx), 64'd6);
    chk("stall_all_recv", 64'(q.size()), 64'd0);
    in_valid = 1'b0; out_ready = 1'b1;

    pending = 1'b0;
    for (int k = 0; k < 150; k++) begin
      out_ready = 1'($urandom_range(0, 1));
      if (!pending && $urandom_range(0, 2) != 0) begin
        A = rnd_op(); B = rnd_op();
        ref_mul(A, B, cur_d, cur_f);
        pending = 1'b1;
      end
      in_valid = pending;
      cyc();
      if (last_acc) pending = 1'b0;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    drain();

    lat_mode = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; A = rnd_op(); B = rnd_op();
      ref_mul(A, B, cur_d, cur_f);
      cyc();
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("post_rst_valid", 64'(out_valid), 64'd0);
    end
    A = 32'hBF800000; B = 32'h3F800000; cur_d = 32'hBF800000; cur_f = 4'b0000;
    in_valid = 1'b1;
    cyc();
    chk("post_rst_accept", 64'(last_acc), 64'd1);
    in_valid = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_mul_pipe.md
FP_MUL_PIPE -- requirements
Module: fp_mul_pipe

Interface
REQ-001 SHALL have parameter EW, default 8, exponent field width, legal range 4..11.
REQ-002 SHALL have parameter MW, default 23, stored mantissa (fraction) width, legal range 4..52.
REQ-003 SHALL derive W = 1+EW+MW and BIAS = 2^(EW-1)-1.
REQ-004 SHALL have one clock and a synchronous, active-high reset.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 in_valid  input  1  operand pair A,B presented this cycle.
REQ-008 in_ready  output  1  block accepts an operand pair this cycle.
REQ-009 A  input  W  IEEE-754-style operand {sign, exp[EW], frac[MW]}.
REQ-010 B  input  W  second operand, same format as A.
REQ-011 out_valid  output  1  out_data/out_flags hold a valid result.
REQ-012 out_ready  input  1  consumer accepts the result this cycle.
REQ-013 out_data  output  W  product in the same format as A.
REQ-014 out_flags  output  4  {invalid, overflow, underflow, inexact} for out_data.

Function
REQ-015 SHALL be a 3-stage pipeline: S1 unpack/classify/mantissa multiply, S2 normalise/exponent, S3 round/pack into output registers.
REQ-016 SHALL accept a pair on the edge where in_valid && in_ready; each stage SHALL carry its own valid bit.
REQ-017 SHALL assert out_valid exactly 3 cycles after acceptance when there are no stalls.
REQ-018 SHALL stall globally when out_valid && !out_ready: every stage holds, and in_ready = !(out_valid && !out_ready), combinational.
REQ-019 SHALL sustain one result per cycle with out_ready=1; results SHALL leave in acceptance order, none dropped or duplicated.
REQ-020 Once asserted, out_valid SHALL stay high, and out_data/out_flags stable, until accepted.
REQ-021 SHALL treat exp==0 inputs as signed zero (denormals-are-zero).
REQ-022 Output sign = sA ^ sB in all non-NaN cases.
REQ-023 SHALL produce product mantissa {1,fA}*{1,fB}, 2*MW+2 bits, with no truncation before rounding.
REQ-024 SHALL compute the exponent as a signed value eA+eB-BIAS+norm in EW+2 bits, where norm=1 if the product MSB is set.
REQ-025 SHALL round to nearest, ties to even, using guard, round and sticky bits; inexact=1 if any discarded bit is nonzero.
REQ-026 A rounding carry out of the mantissa SHALL renormalise (mantissa 0, exponent+1) before the overflow check.
REQ-027 Final exponent >= 2^EW-1 SHALL give signed infinity (exp all ones, frac 0) with overflow=1 and inexact=1.
REQ-028 Final exponent <= 0 SHALL give signed zero (flush-to-zero) with underflow=1 and inexact=1.
REQ-029 Any NaN input, or inf*zero, SHALL give canonical qNaN {0, all ones, 1 followed by MW-1 zeros}; invalid=1 only for inf*zero or an sNaN input.
REQ-030 inf*finite-nonzero SHALL give signed infinity with flags 0; zero*finite SHALL give signed zero with flags 0.
REQ-031 in_valid SHALL be ignored while in_ready=0; the source holds the operands.

Reset
REQ-032 On rst=1 at a clock edge: out_valid=0, out_data=0, out_flags=0, all stage valid bits cleared.
REQ-033 Reset mid-operation SHALL discard every in-flight operation; no stale result SHALL appear after rst deasserts.
REQ-034 in_ready SHALL follow REQ-018 during reset (1 after the first reset edge); pairs presented while rst=1 SHALL NOT be accepted.

Verification (EW=8, MW=23)
REQ-035 A=0x40400000, B=0x40000000, accepted at cycle 0 -> out_valid at cycle 3, out_data=0x40C00000, flags 0000.
REQ-036 A=0x3F800001, B=0x3F800001 -> 0x3F800002, flags 0001 (inexact); A=0xBF800000, B=0x3F800000 -> 0xBF800000, flags 0000.
REQ-037 A=0x7F7FFFFF, B=0x40000000 -> 0x7F800000, flags 0101; A=0x00800000, B=0x3F000000 -> 0x00000000, flags 0011.
REQ-038 A=0x7F800000, B=0x00000000 -> 0x7FC00000, flags 1000; A=0xFF800000, B=0x40000000 -> 0xFF800000, flags 0000.
REQ-039 Back-to-back stream of 6 pairs with out_ready held 0 for cycles 4-7:
- in_ready=0 while stalled;
- all 6 results delivered in order, each exactly once.
REQ-040 Assert rst for 1 cycle while 2 operations are in flight:
- out_valid stays 0 for the following 3 cycles;
- the next accepted pair's result appears 3 cycles after acceptance.
